sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the single shared 16-bit asynchronous SRAM used by the pedal-board effects (delay line on port 0, looper on port 1).
- Accepts one read or write command per port.
- Grants ports round-robin.
- Generates all SRAM strobes and controls the DQ tri-state.
- Returns read data with a per-port valid pulse.

The effects never drive the SRAM pins directly; this block sits between them and the chip pins.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
ACCESS_CYCLES, 2, cycles strobes are held per access; legal 1..15; 0 is treated as 1

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
REQ0  in  1  port 0 request; hold high with command stable until GNT0 seen
WE0  in  1  port 0: 1 = write, 0 = read
ADDR0  in  ADDR_W  port 0 address
WDATA0  in  DATA_W  port 0 write data
GNT0  out  1  one-cycle pulse: port 0 command captured
RVALID0  out  1  one-cycle pulse: RDATA holds port 0 read result
REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1  same as port 0, for port 1
RDATA  out  DATA_W  read data, shared by both ports, qualified by RVALIDx
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_DQ  inout  DATA_W  SRAM data; driven only during write ACCESS, else high-Z
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1  active-low SRAM strobes

Behaviour:
- All outputs are registered.
- Reset (async, RESET_N=0), values immediate, held while low:
  - state = IDLE
  - GNT0/1 = 0, RVALID0/1 = 0, RDATA = 0, SRAM_ADDR = 0
  - all SRAM_*_N = 1, SRAM_DQ = Z
  - last_grant = 1, so port 0 wins the first tie
  - access counter = 0
- Reset mid-access aborts the access. No GNT/RVALID is issued for it, and DQ is released immediately.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - Sample REQ0/REQ1 each cycle.
  - One requester: grant it.
  - Both requesting: grant the port != last_grant, then update last_grant.
  - On grant at edge ending cycle k:
    - Latch WE/ADDR/WDATA of the winner.
    - Pulse GNTx high for cycle k+1 only.
    - Go to ACCESS with counter = ACCESS_CYCLES-1.
  - No request: stay in IDLE, strobes inactive.
- ACCESS (cycles k+1 .. k+ACCESS_CYCLES):
  - SRAM_ADDR = latched address; CE_N = UB_N = LB_N = 0.
  - Read: OE_N = 0, WE_N = 1, DQ = Z.
  - Write: WE_N = 0, OE_N = 1, DQ = latched WDATA.
  - Counter decrements each cycle. At the edge ending the cycle where counter == 0:
    - Read: RDATA <= SRAM_DQ and RVALIDx pulses for one cycle (cycle k+ACCESS_CYCLES+1).
    - Go to RECOVER.
- RECOVER (one cycle):
  - All strobes = 1, DQ = Z. This is the bus turnaround.
  - RDATA holds its value until the next read completes.
  - Go to IDLE.
- Timing:
  - Per-access occupancy = ACCESS_CYCLES+2 cycles (IDLE sample + ACCESS + RECOVER).
  - Read latency from request sampled to RVALID = ACCESS_CYCLES+1 cycles.
- Requests arriving during ACCESS/RECOVER wait; they are sampled at the next IDLE.
- A requester may keep REQ high for back-to-back commands. After GNT it must present the next command before the following IDLE cycle.
- Starvation-free: with both REQ held high, grants alternate 0,1,0,1…
- Writes produce no RVALID.
- DQ is never driven in the same cycle OE_N = 0.
- ADDR wrap and range checks are the requester's responsibility; the address passes through unmodified.

Test Plan:
1. Reset: RESET_N=0 mid-write to addr 0x00010 → strobes immediately 1, DQ=Z, no GNT1/RVALID1; after release, state IDLE.
2. Single write then read, port 0, ACCESS_CYCLES=2:
   - Write 0xBEEF @0x00123 → GNT0 at cycle k+1, WE_N=0 for 2 cycles with DQ=0xBEEF.
   - Read @0x00123 → RVALID0 3 cycles after request sampled, RDATA=0xBEEF.
3. Simultaneous REQ0 and REQ1 reads after reset, both held high → grant order 0,1,0,1. Each RVALID matches its port and the SRAM model's data at that port's address.
4. Port 1 write 0x1234 @0xFFFFF while port 0 requests mid-access → port 0 granted only at next IDLE, exactly 4 cycles after GNT1. Port 1 data intact on readback.
5. Bus contention check: random mixed read/write traffic, 1000 accesses → DQ never driven while OE_N=0; RECOVER cycle present between every pair of accesses.
6. ACCESS_CYCLES=0 → behaves identically to 1: occupancy 3 cycles, read latency 2.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two command ports plus the shared read-data return.
// master = effect (requester) side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              REQ0;
  logic              WE0;
  logic [ADDR_W-1:0] ADDR0;
  logic [DATA_W-1:0] WDATA0;
  logic              GNT0;
  logic              RVALID0;

  logic              REQ1;
  logic              WE1;
  logic [ADDR_W-1:0] ADDR1;
  logic [DATA_W-1:0] WDATA1;
  logic              GNT1;
  logic              RVALID1;

  logic [DATA_W-1:0] RDATA;

  modport master (
    output REQ0, WE0, ADDR0, WDATA0,
    output REQ1, WE1, ADDR1, WDATA1,
    input  GNT0, RVALID0, GNT1, RVALID1, RDATA
  );

  modport slave (
    input  REQ0, WE0, ADDR0, WDATA0,
    input  REQ1, WE1, ADDR1, WDATA1,
    output GNT0, RVALID0, GNT1, RVALID1, RDATA
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for the shared 16-bit asynchronous SRAM.
// Every output, including the DQ output enable, comes straight from a flop.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  // A zero setting still needs one strobe cycle; the 4-bit counter caps it at 15.
  localparam int CYCLES = (ACCESS_CYCLES < 1) ? 1 : ((ACCESS_CYCLES > 15) ? 15 : ACCESS_CYCLES);
  localparam logic [3:0] CNT_INIT = 4'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dq_oe_q, dq_oe_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic              win;
  logic              win_we;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    dq_oe_d      = dq_oe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;

    // On a tie the port that did not win last time goes next, so neither effect starves.
    win    = (bus.REQ0 && bus.REQ1) ? ~last_grant_q : bus.REQ1;
    win_we = win ? bus.WE1 : bus.WE0;

    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          last_grant_d = win;
          port_d       = win;
          we_d         = win_we;
          addr_d       = win ? bus.ADDR1 : bus.ADDR0;
          wdata_d      = win ? bus.WDATA1 : bus.WDATA0;
          gnt0_d       = ~win;
          gnt1_d       = win;
          cnt_d        = CNT_INIT;
          ce_n_d       = 1'b0;
          oe_n_d       = win_we;
          we_n_d       = ~win_we;
          dq_oe_d      = win_we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          state_d = RECOVER;
          if (!we_q) begin
            rdata_d   = SRAM_DQ;
            rvalid0_d = ~port_q;
            rvalid1_d = port_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      port_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      dq_oe_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      dq_oe_q      <= dq_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign bus.GNT0    = gnt0_q;
  assign bus.GNT1    = gnt1_q;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA   = rdata_q;

  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_UB_N = ce_n_q;
  assign SRAM_LB_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;

endmodule
